// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg: shared state encoding and width limits for the serial subtractor
package serial_sub_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/fullsubs.sv
// fullsubs: 1-bit full subtractor cell, diff = a - b - c with borrow out
module fullsubs (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borr
);
  assign diff = a ^ b ^ c;
  assign borr = (~a & b) | (~(a ^ b) & c);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial LSB-first a - b over WIDTH cycles using one fullsubs cell
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  import serial_sub_ctrl_pkg::*;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CW-1:0] cnt;
  logic brw, cell_d, cell_b;
  fullsubs u_cell (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .c(brw),
    .diff(cell_d),
    .borr(cell_b)
  );
  // result fills from the MSB so the word is aligned after WIDTH shifts
  assign r_nxt = {cell_d, r_sh[WIDTH-1:1]};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      brw <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        a_sh <= a;
        b_sh <= b;
        brw <= 1'b0;
        cnt <= '0;
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nxt;
      brw <= cell_b;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= DONE;
        diff <= r_nxt;
        borrow_out <= cell_b;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It sequences the existing 1-bit full subtractor cell (fullsubs) LSB-first over WIDTH cycles, holding the inter-bit borrow in a register. A start/busy/done handshake lets an upstream controller request D = A - B without instantiating a WIDTH-bit parallel subtractor. It sits beside the behavioural arithmetic cells as their first sequenced consumer.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  (a - b) mod 2^WIDTH, registered
borrow_out  output  1  final borrow; 1 iff a < b unsigned

Behaviour:
- One clock: clk. Reset is synchronous and active-high (rst); rst sampled high on a rising edge forces reset state. No asynchronous path.
- Reset values:
  - state=IDLE; busy=0; done=0; diff=0; borrow_out=0.
  - Internal operand shift registers, result shift register, borrow register and bit counter all 0.
- FSM states and transitions:
  - IDLE -> RUN when start=1. On that edge: latch a and b into shift registers, clear the borrow register, set cnt=0.
  - RUN -> RUN while cnt < WIDTH-1. Each edge:
    - Feed the cell x=a_sh[0], y=b_sh[0], bin=borrow reg.
    - Shift the cell's diff bit into the result register MSB (shift right).
    - Shift a_sh and b_sh right by 1; load the borrow reg with the cell's borrow; cnt+1.
  - RUN -> DONE on the edge where cnt == WIDTH-1. Same bit processing as above.
  - In that same edge: diff <= completed result word, borrow_out <= final cell borrow.
  - DONE -> IDLE unconditionally on the next edge.
- Outputs:
  - done = (state==DONE); busy = (state!=IDLE).
  - Both are decoded from the state register, with no combinational path from inputs.
- Latency: start accepted at edge E0; done high in the cycle following edge E0+WIDTH. For WIDTH=8, done is visible after the 8th edge post-accept.
- Throughput: one operation per WIDTH+2 cycles, including the IDLE re-accept. If start is held high, an accept occurs every WIDTH+2 edges.
- start while busy (RUN or DONE): ignored, not queued. a and b changing during RUN have no effect.
- diff and borrow_out hold the previous result from DONE entry until the next DONE entry. They are not cleared on accept; only rst clears them.
- Arithmetic:
  - Result equals two's-complement a - b truncated to WIDTH bits.
  - borrow_out is the unsigned underflow flag.
  - a == b gives diff=0, borrow_out=0.
- Reset mid-operation: rst in RUN or DONE aborts on that edge, with all outputs at reset values. No done pulse is generated for the aborted operation.
- rst and start both high on the same edge: rst wins.
- Counter width: $clog2(WIDTH) bits. No wrap occurs, because the exit compare is at WIDTH-1.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH range limits as localparams.
- One sub-module: the existing 1-bit full subtractor cell fullsubs, instantiated once as the datapath.
  - Its ports (a, b, c, diff, borr) connect to a_sh[0], b_sh[0], the borrow register and the next-state logic.
- Everything else (FSM, shift registers, counter) lives in serial_sub_ctrl.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, start pulse -> busy 1 for 9 cycles; done exactly one cycle, 8 edges after accept; diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1. Then a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0, with the previous result held until the second done.
- Accept a=8'h10, b=8'h01; pulse start with a=8'h77 during RUN at cycle 3 -> ignored; diff=8'h0F; no second done.
- rst high at edge 4 of RUN -> next cycle busy=0, done=0, diff=0, borrow_out=0. A following op with a=8'h03, b=8'h05 gives diff=8'hFE, borrow_out=1.
- start held high for 40 cycles with constant a=8'h80, b=8'h01 -> done pulses every 10 cycles; diff=8'h7F each time.
- Random regression, 1000 ops at WIDTH=8 and WIDTH=13 -> diff == (a-b) mod 2^WIDTH and borrow_out == (a<b) on every done.
